bf_sched: RTL and testbench

BF_SCHED -- requirements
Module: bf_sched

---
 rtl/bf_sched.sv | 150 +++++++++++++++
 tb/tb_bf_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bf_sched.sv
// NTT/INTT butterfly address scheduler.
// Issues one operand pair per cycle and replays its addresses BF_LAT cycles later.
module bf_sched #(
  parameter int LOG_N  = 8,
  parameter int BF_LAT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-1:0] tw_addr,
  output logic             bf_sel,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b,
  output logic [LOG_N-1:0] stage
);

  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);
  localparam logic [LOG_N-1:0] J_LAST = LOG_N'(N / 2 - 1);
  localparam logic [LOG_N-1:0] S_LAST = LOG_N'(LOG_N - 1);
  localparam logic [BF_LAT-1:0] PEND_MASK = {BF_LAT{1'b1}} >> 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [LOG_N-1:0] j, j_n;
  logic [LOG_N-1:0] s, s_n;
  logic             mode_q, mode_n;

  logic [BF_LAT-1:0] sr_v;
  logic [LOG_N-1:0]  sr_a [BF_LAT];
  logic [LOG_N-1:0]  sr_b [BF_LAT];

  logic             issue;
  logic             drained;
  logic [LOG_N-1:0] lh, g, k, a, b, tw;

  // lh = log2(h): butterfly span shrinks per stage for CT, grows for GS
  assign lh = mode_q ? s : S_LAST - s;
  assign g  = j >> lh;
  assign k  = j & ((ONE << lh) - ONE);
  assign a  = (g << (lh + ONE)) | k;
  assign b  = a + (ONE << lh);
  assign tw = (ONE << (S_LAST - lh)) + g;

  assign issue   = (state == RUN) && !hold;
  // only the entry being written this cycle may remain in flight
  assign drained = (sr_v & PEND_MASK) == '0;

  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      j      <= '0;
      s      <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_n;
      j      <= j_n;
      s      <= s_n;
      mode_q <= mode_n;
    end
  end

  // next-state logic: issue, drain, advance stage
  always_comb begin
    state_n = state;
    j_n     = j;
    s_n     = s;
    mode_n  = mode_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          j_n     = '0;
          s_n     = '0;
          mode_n  = mode;
        end
      end
      RUN: begin
        if (!hold) begin
          if (j == J_LAST) begin
            j_n     = '0;
            state_n = DRAIN;
          end else begin
            j_n = j + ONE;
          end
        end
      end
      DRAIN: begin
        if (drained) begin
          if (s == S_LAST) begin
            state_n = DONE;
          end else begin
            s_n     = s + ONE;
            state_n = RUN;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        s_n     = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // in-flight valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_v <= '0;
    end else begin
      sr_v[0] <= issue;
      for (int i = 1; i < BF_LAT; i++) begin
        sr_v[i] <= sr_v[i-1];
      end
    end
  end

  // in-flight addresses, qualified by the valid bits
  always_ff @(posedge clk) begin
    sr_a[0] <= a;
    sr_b[0] <= b;
    for (int i = 1; i < BF_LAT; i++) begin
      sr_a[i] <= sr_a[i-1];
      sr_b[i] <= sr_b[i-1];
    end
  end

  assign rd_en     = issue;
  assign rd_addr_a = issue ? a : '0;
  assign rd_addr_b = issue ? b : '0;
  assign tw_addr   = issue ? tw : '0;
  assign wr_en     = sr_v[BF_LAT-1];
  assign wr_addr_a = wr_en ? sr_a[BF_LAT-1] : '0;
  assign wr_addr_b = wr_en ? sr_b[BF_LAT-1] : '0;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign stage     = s;
  assign bf_sel    = mode_q;

endmodule

// File: tb/tb_bf_sched.sv
// Directed bench for bf_sched, LOG_N = 3, BF_LAT = 10.
// Cycle 0 is the cycle in which start is sampled.
module tb_bf_sched;

  localparam int LN  = 3;
  localparam int LAT = 10;

  logic          clk = 1'b0;
  logic          rst, start, mode, hold;
  logic          busy, done, rd_en, bf_sel, wr_en;
  logic [LN-1:0] rd_addr_a, rd_addr_b, tw_addr;
  logic [LN-1:0] wr_addr_a, wr_addr_b, stage;

  int total = 0;
  int bad   = 0;
  int iss [12];

  logic [2:0] ntt_a  [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  logic [2:0] ntt_b  [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  logic [2:0] ntt_tw [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
  logic [2:0] int_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  logic [2:0] int_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  logic [2:0] int_tw [12] = '{4, 5, 6, 7, 2, 2, 3, 3, 1, 1, 1, 1};

  bf_sched #(.LOG_N(LN), .BF_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .hold(hold),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .bf_sel(bf_sel), .wr_en(wr_en),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .stage(stage)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // nominal issue cycles: stage s at 1 + 14*s + j
  task automatic set_iss();
    for (int i = 0; i < 12; i++) iss[i] = 1 + 14 * (i / 4) + (i % 4);
  endtask

  function automatic logic [9:0] exp_rd(int c, bit m);
    exp_rd = '0;
    for (int i = 0; i < 12; i++)
      if (iss[i] == c)
        exp_rd = m ? {1'b1, int_a[i], int_b[i], int_tw[i]}
                   : {1'b1, ntt_a[i], ntt_b[i], ntt_tw[i]};
  endfunction

  function automatic logic [6:0] exp_wr(int c, bit m);
    exp_wr = '0;
    for (int i = 0; i < 12; i++)
      if (iss[i] + LAT == c)
        exp_wr = m ? {1'b1, int_a[i], int_b[i]}
                   : {1'b1, ntt_a[i], ntt_b[i]};
  endfunction

  function automatic logic [2:0] exp_stage(int c, int s1, int s2, int dn);
    if (c >= 1 && c < s1) exp_stage = 3'd0;
    else if (c >= s1 && c < s2) exp_stage = 3'd1;
    else if (c >= s2 && c <= dn) exp_stage = 3'd2;
    else exp_stage = 3'd0;
  endfunction

  task automatic launch(bit m);
    tick();
    start = 1'b1;
    mode  = m;
    hold  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = 1'b1; hold = 1'b0;
    tick();
    tick();
    rst = 1'b0; start = 1'b0; mode = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b exp=0", done);
    end
    total++;
    if ({rd_en, rd_addr_a, rd_addr_b, tw_addr} !== 10'd0) begin
      bad++; $display("FAIL reset_rd got=%b%h%h%h exp=0",
                      rd_en, rd_addr_a, rd_addr_b, tw_addr);
    end
    total++;
    if ({wr_en, wr_addr_a, wr_addr_b} !== 7'd0) begin
      bad++; $display("FAIL reset_wr got=%b%h%h exp=0",
                      wr_en, wr_addr_a, wr_addr_b);
    end
    total++;
    if ({stage, bf_sel} !== 4'd0) begin
      bad++; $display("FAIL reset_stage_sel got=%h/%b exp=0/0", stage, bf_sel);
    end
  endtask

  task automatic test_xform(bit m);
    set_iss();
    launch(m);
    for (int c = 1; c <= 50; c++) begin
      tick();
      start = 1'b0;
      #1;
      total++;
      if ({rd_en, rd_addr_a, rd_addr_b, tw_addr} !== exp_rd(c, m)) begin
        bad++; $display("FAIL xform%0d_rd c=%0d got=%b exp=%b", m, c,
                        {rd_en, rd_addr_a, rd_addr_b, tw_addr}, exp_rd(c, m));
      end
      total++;
      if ({wr_en, wr_addr_a, wr_addr_b} !== exp_wr(c, m)) begin
        bad++; $display("FAIL xform%0d_wr c=%0d got=%b exp=%b", m, c,
                        {wr_en, wr_addr_a, wr_addr_b}, exp_wr(c, m));
      end
      total++;
      if ({busy, done, bf_sel, stage} !==
          {c <= 43, c == 43, m, exp_stage(c, 15, 29, 43)}) begin
        bad++; $display("FAIL xform%0d_ctl c=%0d got=%b%b%b%h exp=%b%b%b%h",
                        m, c, busy, done, bf_sel, stage,
                        c <= 43, c == 43, m, exp_stage(c, 15, 29, 43));
      end
    end
  endtask

  task automatic test_hold();
    set_iss();
    for (int i = 5; i < 12; i++) iss[i] = iss[i] + 3;
    launch(1'b0);
    for (int c = 1; c <= 50; c++) begin
      tick();
      start = 1'b0;
      hold  = (c >= 16 && c <= 18);
      #1;
      total++;
      if ({rd_en, rd_addr_a, rd_addr_b, tw_addr} !== exp_rd(c, 1'b0)) begin
        bad++; $display("FAIL hold_rd c=%0d got=%b exp=%b", c,
                        {rd_en, rd_addr_a, rd_addr_b, tw_addr}, exp_rd(c, 1'b0));
      end
      total++;
      if ({wr_en, wr_addr_a, wr_addr_b} !== exp_wr(c, 1'b0)) begin
        bad++; $display("FAIL hold_wr c=%0d got=%b exp=%b", c,
                        {wr_en, wr_addr_a, wr_addr_b}, exp_wr(c, 1'b0));
      end
      total++;
      if ({busy, done, stage} !== {c <= 46, c == 46, exp_stage(c, 15, 32, 46)}) begin
        bad++; $display("FAIL hold_ctl c=%0d got=%b%b%h exp=%b%b%h", c,
                        busy, done, stage, c <= 46, c == 46,
                        exp_stage(c, 15, 32, 46));
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_iss();
    launch(1'b1);
    for (int c = 1; c <= 70; c++) begin
      tick();
      start = (c == 25);
      mode  = 1'b0;
      rst   = (c == 20);
      #1;
      if (c <= 20) begin
        total++;
        if ({rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b}
            !== {exp_rd(c, 1'b1), exp_wr(c, 1'b1)}) begin
          bad++; $display("FAIL rstmid_pre c=%0d got=%b%b exp=%b%b", c,
                          {rd_en, rd_addr_a, rd_addr_b, tw_addr},
                          {wr_en, wr_addr_a, wr_addr_b},
                          exp_rd(c, 1'b1), exp_wr(c, 1'b1));
        end
      end else begin
        if (c <= 25) begin
          total++;
          if ({busy, done, bf_sel, stage} !== 6'd0) begin
            bad++; $display("FAIL rstmid_zero c=%0d got=%b%b%b%h exp=0", c,
                            busy, done, bf_sel, stage);
          end
        end
        total++;
        if ({rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b}
            !== {exp_rd(c - 25, 1'b0), exp_wr(c - 25, 1'b0)}) begin
          bad++; $display("FAIL rstmid_post c=%0d got=%b%b exp=%b%b", c,
                          {rd_en, rd_addr_a, rd_addr_b, tw_addr},
                          {wr_en, wr_addr_a, wr_addr_b},
                          exp_rd(c - 25, 1'b0), exp_wr(c - 25, 1'b0));
        end
        total++;
        if (done !== (c == 68)) begin
          bad++; $display("FAIL rstmid_done c=%0d got=%b exp=%b", c, done, c == 68);
        end
      end
    end
  endtask

  task automatic test_start_busy();
    set_iss();
    launch(1'b0);
    for (int c = 1; c <= 50; c++) begin
      tick();
      start = (c == 5 || c == 43);
      mode  = c[0];
      #1;
      total++;
      if ({rd_en, rd_addr_a, rd_addr_b, tw_addr} !== exp_rd(c, 1'b0)) begin
        bad++; $display("FAIL sbusy_rd c=%0d got=%b exp=%b", c,
                        {rd_en, rd_addr_a, rd_addr_b, tw_addr}, exp_rd(c, 1'b0));
      end
      total++;
      if ({busy, done, bf_sel} !== {c <= 43, c == 43, 1'b0}) begin
        bad++; $display("FAIL sbusy_ctl c=%0d got=%b%b%b exp=%b%b0", c,
                        busy, done, bf_sel, c <= 43, c == 43);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_xform(1'b0);
    test_xform(1'b1);
    test_hold();
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
